// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the I-memory.
interface if_stage_if;
   logic        proc2Imem_req;
   logic [31:0] proc2Imem_addr;
   logic        Imem2proc_gnt;
   logic        Imem2proc_rvld;
   logic [31:0] Imem2proc_data;

   modport master (
      output proc2Imem_req,
      output proc2Imem_addr,
      input  Imem2proc_gnt,
      input  Imem2proc_rvld,
      input  Imem2proc_data
   );

   modport slave (
      input  proc2Imem_req,
      input  proc2Imem_addr,
      output Imem2proc_gnt,
      output Imem2proc_rvld,
      output Imem2proc_data
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: in-order requests, 2-entry instruction buffer, redirect flush.
// Define IF_BREAK_HALT_EN to halt fetching after an EBREAK/SYSTEM-opcode word is buffered.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ID_stall,
   input  logic        redirect_vld,
   input  logic [31:0] redirect_pc,
   if_stage_if.master  imem,
   output logic [31:0] IF_ID_pc,
   output logic [31:0] IF_ID_inst,
   output logic        IF_ID_vld
);

   localparam logic [31:0] NOP_INST   = 32'h0000_0013;
   localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

   typedef enum logic {RUN, HALT} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [1:0]  ocnt_q, ocnt_d;
   logic [1:0]  drop_q, drop_d;
   logic [31:0] bpc_q [2];
   logic [31:0] bpc_d [2];
   logic [31:0] binst_q [2];
   logic [31:0] binst_d [2];
   logic [31:0] opc_q [2];
   logic [31:0] opc_d [2];

   logic       vld, pop, req, accept, resp, discard, wr, ebreak;
   logic [1:0] bcnt_pop, ocnt_pop;

   assign vld      = !rst && (bcnt_q != 2'd0);
   assign pop      = vld && !ID_stall;
   assign bcnt_pop = bcnt_q - {1'b0, pop};
   assign ocnt_pop = ocnt_q - {1'b0, resp};
   // Occupancy counts the slot freed by this cycle's pop so streaming sustains one word per cycle.
   assign req      = !rst && (state_q == RUN) && !redirect_vld &&
                     (({1'b0, ocnt_q} + {1'b0, bcnt_pop}) < 3'd2);
   assign accept   = req && imem.Imem2proc_gnt;
   // A response with nothing outstanding belongs to a request issued before reset.
   assign resp     = imem.Imem2proc_rvld && (ocnt_q != 2'd0);
   assign discard  = resp && (drop_q != 2'd0);
   assign wr       = resp && (drop_q == 2'd0);

`ifdef IF_BREAK_HALT_EN
   assign ebreak = wr && (imem.Imem2proc_data[6:0] == OPC_SYSTEM);
`else
   assign ebreak = 1'b0;
`endif

   assign imem.proc2Imem_req  = req;
   assign imem.proc2Imem_addr = fetch_pc_q;
   assign IF_ID_vld           = vld;
   assign IF_ID_pc            = vld ? bpc_q[0] : 32'h0000_0000;
   assign IF_ID_inst          = vld ? binst_q[0] : NOP_INST;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      bcnt_d     = bcnt_q;
      ocnt_d     = ocnt_q;
      drop_d     = drop_q;
      bpc_d      = bpc_q;
      binst_d    = binst_q;
      opc_d      = opc_q;

      // Outstanding-request PCs: retire the oldest on a response, append on a grant.
      if (resp) begin
         opc_d[0] = opc_q[1];
      end
      if (accept) begin
         opc_d[ocnt_pop[0]] = fetch_pc_q;
         fetch_pc_d         = fetch_pc_q + 32'd4;
      end
      ocnt_d = ocnt_pop + {1'b0, accept};
      drop_d = drop_q - {1'b0, discard};

      if (pop) begin
         bpc_d[0]   = bpc_q[1];
         binst_d[0] = binst_q[1];
      end
      if (wr) begin
         bpc_d[bcnt_pop[0]]   = opc_q[0];
         binst_d[bcnt_pop[0]] = imem.Imem2proc_data;
      end
      bcnt_d = bcnt_pop + {1'b0, wr};

      if (ebreak) begin
         state_d = HALT;
         drop_d  = ocnt_d;
      end

      // Redirect wins over everything else; this cycle's response (if any) is already retired above.
      if (redirect_vld) begin
         state_d    = RUN;
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         bcnt_d     = 2'd0;
         drop_d     = ocnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         bcnt_q     <= 2'd0;
         ocnt_q     <= 2'd0;
         drop_q     <= 2'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         bcnt_q     <= bcnt_d;
         ocnt_q     <= ocnt_d;
         drop_q     <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      bpc_q   <= bpc_d;
      binst_q <= binst_d;
      opc_q   <= opc_d;
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random traffic against a queue-based model.
module tb_if_stage;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBRK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst, ID_stall, redirect_vld;
   logic [31:0] redirect_pc;
   logic [31:0] IF_ID_pc, IF_ID_inst;
   logic        IF_ID_vld;

   if_stage_if imem ();

   if_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .ID_stall(ID_stall), .redirect_vld(redirect_vld),
      .redirect_pc(redirect_pc), .imem(imem), .IF_ID_pc(IF_ID_pc),
      .IF_ID_inst(IF_ID_inst), .IF_ID_vld(IF_ID_vld)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // memory environment
   int          gnt_pct, rvld_pct;
   logic [31:0] ebreak_addr;
   logic [31:0] memq[$];

   // reference model state
   logic [31:0] m_out_pc[$];
   logic [31:0] m_buf_pc[$];
   logic [31:0] m_buf_inst[$];
   int          m_drop;
   bit          m_halt;
   logic [31:0] m_fpc;

   logic        obs_req, obs_vld;
   logic [31:0] obs_addr, obs_pc, obs_inst;

   function automatic logic [31:0] word(input logic [31:0] a);
      if (a == ebreak_addr) return EBRK;
      return {a[26:2] ^ 25'h0A5A5A5, 7'h13};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic        g, rv, pop, exp_vld, exp_req, resp;
      logic [31:0] d, exp_pc, exp_inst;
      int          occ;
      g  = ($urandom_range(0, 99) < gnt_pct);
      rv = (memq.size() > 0) && ($urandom_range(0, 99) < rvld_pct);
      d  = rv ? word(memq[0]) : $urandom;
      imem.Imem2proc_gnt  = g;
      imem.Imem2proc_rvld = rv;
      imem.Imem2proc_data = d;
      @(negedge clk);
      obs_req  = imem.proc2Imem_req;
      obs_addr = imem.proc2Imem_addr;
      obs_vld  = IF_ID_vld;
      obs_pc   = IF_ID_pc;
      obs_inst = IF_ID_inst;
      if (rst) begin
         exp_vld = 1'b0; exp_pc = 32'h0; exp_inst = NOP; exp_req = 1'b0; pop = 1'b0;
      end else begin
         exp_vld  = (m_buf_pc.size() != 0);
         exp_pc   = exp_vld ? m_buf_pc[0] : 32'h0;
         exp_inst = exp_vld ? m_buf_inst[0] : NOP;
         pop      = exp_vld && !ID_stall;
         occ      = m_out_pc.size() + m_buf_pc.size() - int'(pop);
         exp_req  = !m_halt && !redirect_vld && (occ < 2);
      end
      chk("req", 32'(obs_req), 32'(exp_req));
      chk("vld", 32'(obs_vld), 32'(exp_vld));
      chk("pc", obs_pc, exp_pc);
      chk("inst", obs_inst, exp_inst);
      if (!rst) chk("addr", obs_addr, m_fpc);
      @(posedge clk);
      if (rv) void'(memq.pop_front());
      if (obs_req && g) memq.push_back(obs_addr);
      if (rst) begin
         m_out_pc.delete(); m_buf_pc.delete(); m_buf_inst.delete();
         m_drop = 0; m_halt = 1'b0; m_fpc = RST_PC;
      end else begin
         resp = rv && (m_out_pc.size() > 0);
         exp_pc = 32'h0;
         if (resp) exp_pc = m_out_pc.pop_front();
         if (exp_req && g) begin
            m_out_pc.push_back(m_fpc);
            m_fpc = m_fpc + 32'd4;
         end
         if (redirect_vld) begin
            m_buf_pc.delete(); m_buf_inst.delete();
            m_fpc  = redirect_pc & 32'hFFFF_FFFC;
            m_drop = m_out_pc.size();
            m_halt = 1'b0;
         end else begin
            if (pop) begin
               void'(m_buf_pc.pop_front());
               void'(m_buf_inst.pop_front());
            end
            if (resp) begin
               if (m_drop > 0) m_drop--;
               else begin
                  m_buf_pc.push_back(exp_pc);
                  m_buf_inst.push_back(d);
`ifdef IF_BREAK_HALT_EN
                  if (d[6:0] == 7'b1110011) begin
                     m_halt = 1'b1;
                     m_drop = m_out_pc.size();
                  end
`endif
               end
            end
         end
      end
      #1;
   endtask

   initial begin
      logic [31:0] held;
      rst = 1'b1; ID_stall = 1'b0; redirect_vld = 1'b0; redirect_pc = 32'h0;
      gnt_pct = 100; rvld_pct = 100; ebreak_addr = 32'h1;
      imem.Imem2proc_gnt = 1'b0; imem.Imem2proc_rvld = 1'b0; imem.Imem2proc_data = 32'h0;
      m_drop = 0; m_halt = 1'b0; m_fpc = RST_PC;
      @(posedge clk); #1;

      // reset
      repeat (3) cycle();
      chk("rst_vld", 32'(obs_vld), 32'h0);
      chk("rst_inst", obs_inst, NOP);
      rst = 1'b0;

      // streaming: pcs 0,4,8,C from the third cycle after reset
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (k == 1) chk("stream_first_req", obs_addr, RST_PC);
         if (k >= 3 && k <= 6) chk("stream_pc", obs_pc, 32'(4 * (k - 3)));
      end

      // backpressure
      ID_stall = 1'b1;
      held = 32'h0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         if (k == 0) held = obs_pc;
         else chk("bp_hold", obs_pc, held);
      end
      chk("bp_req", 32'(obs_req), 32'h0);
      chk("bp_vld", 32'(obs_vld), 32'h1);
      ID_stall = 1'b0;
      cycle(); chk("bp_rel0", obs_pc, held);
      cycle(); chk("bp_rel1", obs_pc, held + 32'd4);
      cycle(); chk("bp_rel2", obs_pc, held + 32'd8);

      // redirect with two outstanding
      rvld_pct = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (m_out_pc.size() == 2 && m_buf_pc.size() == 0) break;
      end
      chk("rd_setup_outstanding", 32'(m_out_pc.size()), 32'd2);
      redirect_vld = 1'b1; redirect_pc = 32'h100;
      cycle();
      redirect_vld = 1'b0; rvld_pct = 100;
      cycle();
      chk("rd_addr", obs_addr, 32'h100);
      chk("rd_req", 32'(obs_req), 32'h0);
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (obs_vld) break;
      end
      chk("rd_first_pc", obs_pc, 32'h100);

      // redirect colliding with a response and a pop
      repeat (4) cycle();
      redirect_vld = 1'b1; redirect_pc = 32'h206;
      cycle();
      chk("col_pre_vld", 32'(obs_vld), 32'h1);
      redirect_vld = 1'b0;
      cycle();
      chk("col_vld", 32'(obs_vld), 32'h0);
      chk("col_addr", obs_addr, 32'h204);
      chk("col_req", 32'(obs_req), 32'h1);

      // EBREAK word at 0x8
      repeat (3) cycle();
      ebreak_addr = 32'h8;
      redirect_vld = 1'b1; redirect_pc = 32'h0;
      cycle();
      redirect_vld = 1'b0;
      for (int k = 0; k < 12; k++) begin
         cycle();
         if (obs_vld && obs_pc == 32'h8) break;
      end
      chk("eb_pc", obs_pc, 32'h8);
      chk("eb_inst", obs_inst, EBRK);
`ifdef IF_BREAK_HALT_EN
      for (int k = 0; k < 8; k++) begin
         cycle();
         chk("eb_halt_req", 32'(obs_req), 32'h0);
      end
      chk("eb_halt_vld", 32'(obs_vld), 32'h0);
      ebreak_addr = 32'h1;
      redirect_vld = 1'b1; redirect_pc = 32'h300;
      cycle();
      redirect_vld = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (obs_vld) break;
      end
      chk("eb_resume_pc", obs_pc, 32'h300);
`else
      cycle();
      chk("eb_ordinary_vld", 32'(obs_vld), 32'h1);
      chk("eb_ordinary_pc", obs_pc, 32'hC);
      ebreak_addr = 32'h1;
`endif

      // mid-stream reset with two outstanding
      rvld_pct = 0;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (m_out_pc.size() == 2 && m_buf_pc.size() == 0) break;
      end
      chk("mr_setup_outstanding", 32'(m_out_pc.size()), 32'd2);
      rst = 1'b1; rvld_pct = 100;
      repeat (3) cycle();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (obs_vld) break;
      end
      chk("mr_first_pc", obs_pc, RST_PC);
      cycle();
      chk("mr_second_pc", obs_pc, RST_PC + 32'd4);

      // random traffic
      ebreak_addr = 32'h40;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1; redirect_vld = 1'b0; rvld_pct = 100;
            repeat (3) cycle();
            rst = 1'b0;
         end
         ID_stall     = ($urandom_range(0, 99) < 30);
         gnt_pct      = 70;
         rvld_pct     = 60;
         redirect_vld = ($urandom_range(0, 99) < 5);
         redirect_pc  = $urandom & 32'h0000_03FF;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
